// File: rtl/nt_vram_arb.sv
// nt_vram_arb
//   Nametable VRAM with PPU-address decoding, cartridge-selectable mirroring
//   and a two-port arbiter in front of one synchronous single-port RAM.
//   The render port (PPU fetch) has priority. The CPU port (PPUDATA path) uses
//   req/ack and is forced a slot after STARVE_LIMIT consecutive stalled cycles.
//
//   Optional feature macro: NT_VRAM_FOUR_SCREEN_EN
//     defined   -> 4-page RAM, extra input four_screen selects page = addr[11:10]
//     undefined -> 2-page RAM, page chosen by mirror_mode only
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   mirror_mode   00 horizontal, 01 vertical, 10 single-A, 11 single-B
//   four_screen   (NT_VRAM_FOUR_SCREEN_EN only) 4 unique nametables when 1
//   render_en     render read request this cycle
//   render_addr   PPU address of render read
//   render_data   render read data (held when a read is not served)
//   render_valid  render_data valid, one cycle after a served render_en
//   cpu_req       CPU request, held until cpu_ack
//   cpu_we        1 write, 0 read
//   cpu_addr      PPU address of CPU access
//   cpu_wdata     CPU write data
//   cpu_rdata     CPU read data, valid in the ack cycle, held until next read
//   cpu_ack       single-cycle completion pulse
//   cpu_busy      CPU request accepted and not yet acked
//
// CPU FSM
//   state | meaning
//   IDLE  | no CPU access pending; grants at once if the RAM slot is free
//   STALL | request accepted, render owns the RAM; counting stalled cycles
//   ISSUE | access was granted last cycle; RAM read data returns this cycle
//   ACK   | cpu_ack pulse, cpu_rdata updated, stall count cleared

module nt_vram_arb #(
   parameter int DATA_WIDTH   = 8,
   parameter int PAGE_AW      = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            mirror_mode,
`ifdef NT_VRAM_FOUR_SCREEN_EN
   input  logic                  four_screen,
`endif
   input  logic                  render_en,
   input  logic [13:0]           render_addr,
   output logic [DATA_WIDTH-1:0] render_data,
   output logic                  render_valid,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [13:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cpu_busy
);

`ifdef NT_VRAM_FOUR_SCREEN_EN
   localparam int PAGE_BITS = 2;
`else
   localparam int PAGE_BITS = 1;
`endif
   localparam int IDX_W = PAGE_AW + PAGE_BITS;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      ISSUE = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t state, state_nxt;
   logic [3:0] stall_cnt, stall_cnt_nxt;
   logic cpu_go;

   // Latched CPU command, so a request dropped early still completes intact.
   logic                  lat_we;
   logic [11:0]           lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  lat_oor;

   logic                  cmd_we;
   logic [11:0]           cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic render_busy, render_oor, render_take;
   logic rd_ram_q, rd_oor_q;
   logic [DATA_WIDTH-1:0] render_hold;

   logic [PAGE_BITS-1:0] cpu_page, render_page;
   logic [IDX_W-1:0]     cpu_idx, render_idx;

   logic                  ram_en, ram_we;
   logic [IDX_W-1:0]      ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_q;
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   logic unused_bits;
   assign unused_bits = ^{render_addr[12], cpu_addr[12]};

   function automatic logic mirror_page(input logic a11, input logic a10,
                                        input logic [1:0] mode);
      logic pg;
      pg = 1'b0;
      case (mode)
         2'b00:   pg = a11;
         2'b01:   pg = a10;
         2'b10:   pg = 1'b0;
         default: pg = 1'b1;
      endcase
      return pg;
   endfunction

   // In IDLE the grant happens in the request cycle, so the live inputs are
   // used; afterwards only the latched copy is trusted.
   assign cmd_we    = (state == IDLE) ? cpu_we           : lat_we;
   assign cmd_addr  = (state == IDLE) ? cpu_addr[11:0]   : lat_addr;
   assign cmd_wdata = (state == IDLE) ? cpu_wdata        : lat_wdata;

`ifdef NT_VRAM_FOUR_SCREEN_EN
   assign cpu_page    = four_screen ? cmd_addr[11:10]
                      : {1'b0, mirror_page(cmd_addr[11], cmd_addr[10], mirror_mode)};
   assign render_page = four_screen ? render_addr[11:10]
                      : {1'b0, mirror_page(render_addr[11], render_addr[10], mirror_mode)};
`else
   assign cpu_page    = mirror_page(cmd_addr[11], cmd_addr[10], mirror_mode);
   assign render_page = mirror_page(render_addr[11], render_addr[10], mirror_mode);
`endif

   assign cpu_idx    = {cpu_page, cmd_addr[PAGE_AW-1:0]};
   assign render_idx = {render_page, render_addr[PAGE_AW-1:0]};

   // Out-of-range render reads never touch the RAM, leaving the slot free.
   assign render_busy = render_en & render_addr[13];
   assign render_oor  = render_en & ~render_addr[13];
   assign render_take = render_busy & ~cpu_go;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         stall_cnt <= stall_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      stall_cnt_nxt = stall_cnt;
      cpu_go        = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               if (!cpu_addr[13]) begin
                  // Out of range: no RAM slot needed, complete on the fixed timeline.
                  state_nxt = ISSUE;
               end else if (!render_busy) begin
                  cpu_go    = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  // The request cycle itself counts as the first stalled cycle.
                  stall_cnt_nxt = 4'd1;
                  state_nxt     = STALL;
               end
            end
         end
         STALL: begin
            if (stall_cnt >= LIMIT || !render_busy) begin
               cpu_go        = 1'b1;
               stall_cnt_nxt = '0;
               state_nxt     = ISSUE;
            end else begin
               stall_cnt_nxt = stall_cnt + 4'd1;
            end
         end
         ISSUE: begin
            state_nxt = ACK;
         end
         ACK: begin
            stall_cnt_nxt = '0;
            state_nxt     = IDLE;
         end
         default: begin
            stall_cnt_nxt = '0;
            state_nxt     = IDLE;
         end
      endcase
   end

   assign cpu_ack  = (state == ACK);
   assign cpu_busy = (state == STALL) || (state == ISSUE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_oor   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         if (state == IDLE && cpu_req) begin
            lat_we    <= cpu_we;
            lat_addr  <= cpu_addr[11:0];
            lat_wdata <= cpu_wdata;
            lat_oor   <= ~cpu_addr[13];
         end
         if (state == ISSUE && !lat_we) begin
            cpu_rdata <= lat_oor ? '0 : ram_q;
         end
      end
   end

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = render_idx;
      ram_wdata = cmd_wdata;
      if (cpu_go) begin
         ram_en   = 1'b1;
         ram_we   = cmd_we;
         ram_addr = cpu_idx;
      end else if (render_busy) begin
         ram_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
         end else begin
            ram_q <= mem[ram_addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ram_q    <= 1'b0;
         rd_oor_q    <= 1'b0;
         render_hold <= '0;
      end else begin
         rd_ram_q <= render_take;
         rd_oor_q <= render_oor;
         if (rd_ram_q) begin
            render_hold <= ram_q;
         end else if (rd_oor_q) begin
            render_hold <= '0;
         end
      end
   end

   // ram_q may carry CPU data on non-render cycles, so fall back to the hold copy.
   assign render_data  = rd_ram_q ? ram_q : (rd_oor_q ? '0 : render_hold);
   assign render_valid = rd_ram_q | rd_oor_q;

endmodule

// File: tb/tb_nt_vram_arb.sv
module tb_nt_vram_arb;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mirror_mode;
`ifdef NT_VRAM_FOUR_SCREEN_EN
   logic        four_screen;
`endif
   logic        render_en;
   logic [13:0] render_addr;
   logic [7:0]  render_data;
   logic        render_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        cpu_busy;

   int checks;
   int failures;

   nt_vram_arb #(
      .DATA_WIDTH   (8),
      .PAGE_AW      (10),
      .STARVE_LIMIT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mirror_mode  (mirror_mode),
`ifdef NT_VRAM_FOUR_SCREEN_EN
      .four_screen  (four_screen),
`endif
      .render_en    (render_en),
      .render_addr  (render_addr),
      .render_data  (render_data),
      .render_valid (render_valid),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_ack      (cpu_ack),
      .cpu_busy     (cpu_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one CPU access and reports ack latency in cycles (-1 on timeout).
   task automatic cpu_xfer(input logic we, input logic [13:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      lat       = -1;
      rd        = 8'h00;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (cpu_ack) begin
            lat = i;
            rd  = cpu_rdata;
            break;
         end
      end
      cpu_req = 1'b0;
      tick();
   endtask

   task automatic render_rd(input logic [13:0] a, output logic v, output logic [7:0] d);
      render_en   = 1'b1;
      render_addr = a;
      tick();
      v = render_valid;
      d = render_data;
      render_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (render_valid !== 1'b0) begin failures++; $display("FAIL reset_render_valid got=%b exp=0", render_valid); end
      checks++;
      if (render_data !== 8'h00) begin failures++; $display("FAIL reset_render_data got=%h exp=00", render_data); end
      checks++;
      if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0) begin
         failures++; $display("FAIL reset_cpu_flags got ack=%b busy=%b exp 0/0", cpu_ack, cpu_busy);
      end
      checks++;
      if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_vertical();
      int lat;
      logic [7:0] rd;
      mirror_mode = 2'b01;
      cpu_xfer(1'b1, 14'h2005, 8'hA5, lat, rd);
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL vert_write_latency got=%0d exp=2", lat); end
      cpu_xfer(1'b0, 14'h2805, 8'h00, lat, rd);
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL vert_read_latency got=%0d exp=2", lat); end
      checks++;
      if (rd !== 8'hA5) begin failures++; $display("FAIL vert_read_data got=%h exp=a5", rd); end
      checks++;
      if (cpu_rdata !== 8'hA5 || cpu_ack !== 1'b0) begin
         failures++; $display("FAIL vert_rdata_hold got rdata=%h ack=%b exp a5/0", cpu_rdata, cpu_ack);
      end
   endtask

   task automatic test_horizontal();
      int lat;
      logic [7:0] rd;
      logic v;
      logic [7:0] d;
      mirror_mode = 2'b00;
      cpu_xfer(1'b1, 14'h2805, 8'hC3, lat, rd);
      cpu_xfer(1'b1, 14'h2405, 8'h3C, lat, rd);
      render_rd(14'h2005, v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'h3C) begin failures++; $display("FAIL horiz_render_2005 got v=%b d=%h exp 1/3c", v, d); end
      render_rd(14'h2805, v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'hC3) begin failures++; $display("FAIL horiz_render_2805 got v=%b d=%h exp 1/c3", v, d); end
      render_rd(14'h3405, v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'h3C) begin failures++; $display("FAIL horiz_alias_3405 got v=%b d=%h exp 1/3c", v, d); end
      tick();
      checks++;
      if (render_valid !== 1'b0 || render_data !== 8'h3C) begin
         failures++; $display("FAIL horiz_idle_hold got v=%b d=%h exp 0/3c", render_valid, render_data);
      end
   endtask

   task automatic test_single_b();
      int lat;
      logic [7:0] rd;
      logic v;
      logic [7:0] d;
      mirror_mode = 2'b11;
      cpu_xfer(1'b1, 14'h2000, 8'h11, lat, rd);
      render_rd(14'h2C00, v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'h11) begin failures++; $display("FAIL singleb_2c00 got v=%b d=%h exp 1/11", v, d); end
      render_rd(14'h3400, v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'h11) begin failures++; $display("FAIL singleb_3400 got v=%b d=%h exp 1/11", v, d); end
   endtask

   task automatic test_out_of_range();
      int lat;
      logic [7:0] rd;
      logic v;
      logic [7:0] d;
      mirror_mode = 2'b00;
      cpu_xfer(1'b1, 14'h2FFF, 8'h5A, lat, rd);
      cpu_xfer(1'b1, 14'h0FFF, 8'hFF, lat, rd);
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL oor_write_latency got=%0d exp=2", lat); end
      cpu_xfer(1'b0, 14'h2FFF, 8'h00, lat, rd);
      checks++;
      if (rd !== 8'h5A) begin failures++; $display("FAIL oor_write_discarded got=%h exp=5a", rd); end
      cpu_xfer(1'b0, 14'h1000, 8'h00, lat, rd);
      checks++;
      if (lat !== 2 || rd !== 8'h00) begin failures++; $display("FAIL oor_read got lat=%0d d=%h exp 2/00", lat, rd); end
      render_rd(14'h1234, v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL oor_render got v=%b d=%h exp 1/00", v, d); end
   endtask

   task automatic test_starvation();
      int lat;
      logic [7:0] rd;
      mirror_mode = 2'b01;
      cpu_xfer(1'b1, 14'h2005, 8'h5E, lat, rd);
      cpu_xfer(1'b1, 14'h2100, 8'h77, lat, rd);
      render_en   = 1'b1;
      render_addr = 14'h2005;
      cpu_req     = 1'b1;
      cpu_we      = 1'b0;
      cpu_addr    = 14'h2100;
      for (int k = 1; k <= 9; k++) begin
         tick();
         checks++;
         if (render_valid !== ((k == 5) ? 1'b0 : 1'b1)) begin
            failures++; $display("FAIL starve_render_valid_k%0d got=%b exp=%b", k, render_valid, (k != 5));
         end
         checks++;
         if (cpu_ack !== ((k == 6) ? 1'b1 : 1'b0)) begin
            failures++; $display("FAIL starve_ack_k%0d got=%b exp=%b", k, cpu_ack, (k == 6));
         end
         if (k == 5) begin
            checks++;
            if (render_data !== 8'h5E || cpu_busy !== 1'b1) begin
               failures++; $display("FAIL starve_gap_hold got d=%h busy=%b exp 5e/1", render_data, cpu_busy);
            end
         end
         if (k == 6) begin
            checks++;
            if (cpu_rdata !== 8'h77) begin failures++; $display("FAIL starve_rdata got=%h exp=77", cpu_rdata); end
         end
         if (cpu_ack) cpu_req = 1'b0;
      end
      cpu_req   = 1'b0;
      render_en = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_in_stall();
      int lat;
      int stray;
      logic [7:0] rd;
      mirror_mode = 2'b01;
      render_en   = 1'b1;
      render_addr = 14'h2005;
      cpu_req     = 1'b1;
      cpu_we      = 1'b0;
      cpu_addr    = 14'h2100;
      tick();
      tick();
      checks++;
      if (cpu_busy !== 1'b1 || render_valid !== 1'b1) begin
         failures++; $display("FAIL rst_pre_stall got busy=%b v=%b exp 1/1", cpu_busy, render_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0 || render_valid !== 1'b0) begin
         failures++; $display("FAIL rst_async_clear got busy=%b ack=%b v=%b exp 0/0/0", cpu_busy, cpu_ack, render_valid);
      end
      cpu_req   = 1'b0;
      render_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (cpu_ack || cpu_busy) stray++;
      end
      checks++;
      if (stray !== 0) begin failures++; $display("FAIL rst_stray_activity got=%0d exp=0", stray); end
      cpu_xfer(1'b0, 14'h2100, 8'h00, lat, rd);
      checks++;
      if (lat !== 2 || rd !== 8'h77) begin failures++; $display("FAIL rst_ram_kept got lat=%0d d=%h exp 2/77", lat, rd); end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      mirror_mode = 2'b00;
`ifdef NT_VRAM_FOUR_SCREEN_EN
      four_screen = 1'b0;
`endif
      render_en   = 1'b0;
      render_addr = 14'h0000;
      cpu_req     = 1'b0;
      cpu_we      = 1'b0;
      cpu_addr    = 14'h0000;
      cpu_wdata   = 8'h00;
      test_reset();
      test_vertical();
      test_horizontal();
      test_single_b();
      test_out_of_range();
      test_starvation();
      test_reset_in_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
